// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix
//   Parameterised PS/2 set-2 key tracker. Decodes the keyboard byte stream
//   (E0 / F0 prefixes) against a table of NUM_KEYS codes and produces per-key
//   held levels, per-key hold/pulse outputs with optional auto-repeat, and a
//   show-ahead make/break event FIFO with a valid/ready handshake.
//
// Ports
//   clock, reset         : posedge clock, asynchronous active-high reset
//   byte_valid/byte_data : one-cycle strobe plus keyboard byte
//   key_held             : per-key level, high while the key is down
//   key_out              : key_held (hold mode) or press/repeat pulse (pulse mode)
//   any_held             : OR of key_held
//   event_valid/ready    : FIFO head valid / consumer accept
//   event_make/event_key : head event (1 = make, 0 = break) and key index
//   overflow             : sticky, set when an event is dropped
//   overflow_clear       : clears overflow (a same-cycle drop wins)

// Per-key slot: code compare, held level and pulse register.
module ps2_key_slot #(
  parameter logic [8:0] CODE  = 9'h000,
  parameter bit         PULSE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] code,
  output logic       match,
  input  logic       press,
  input  logic       unpress,
  input  logic       clear_all,
  input  logic       rep_tick,
  output logic       held,
  output logic       key_out
);
  logic pulse;

  assign match = (code == CODE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= press | rep_tick;
      if (clear_all)    held <= 1'b0;
      else if (press)   held <= 1'b1;
      else if (unpress) held <= 1'b0;
    end
  end

  assign key_out = PULSE ? pulse : held;
endmodule

module ps2_key_matrix #(
  parameter int                   NUM_KEYS      = 10,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES    = {9'h05A, 9'h029, 9'h172, 9'h175, 9'h174,
                                                   9'h16B, 9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter logic [NUM_KEYS-1:0]  PULSE_MASK    = '0,
  parameter logic [15:0]          REPEAT_DELAY  = 16'd0,
  parameter logic [15:0]          REPEAT_PERIOD = 16'd1,
  parameter int                   EVENT_DEPTH   = 4,
  localparam int                  IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                any_held,
  output logic                event_valid,
  input  logic                event_ready,
  output logic                event_make,
  output logic [IDX_W-1:0]    event_key,
  output logic                overflow,
  input  logic                overflow_clear
);
  localparam int AW        = $clog2(EVENT_DEPTH);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 16'd0);

  // ---------------------------------------------------------------- decoder
  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;
  state_t state, state_n;
  logic   data_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    data_byte = 1'b0;
    if (byte_valid) begin
      if (byte_data == 8'hE0) begin
        state_n = S_EXT;
      end else if (byte_data == 8'hF0) begin
        state_n = (state == S_EXT || state == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
      end else begin
        state_n   = S_IDLE;
        data_byte = 1'b1;
      end
    end
  end

  logic       is_ext, is_brk, self_test, lookup_en;
  logic [8:0] code;

  assign is_ext    = (state == S_EXT) || (state == S_EXT_BRK);
  assign is_brk    = (state == S_BRK) || (state == S_EXT_BRK);
  assign code      = {is_ext, byte_data};
  // Keyboard BAT-pass / error bytes only mean "reset" outside a prefix.
  assign self_test = data_byte && (state == S_IDLE) &&
                     (byte_data == 8'hAA || byte_data == 8'hFC);
  assign lookup_en = data_byte && !self_test;

  // ---------------------------------------------------------------- lookup
  logic [NUM_KEYS-1:0] match;
  logic [IDX_W-1:0]    hit_idx;
  logic                hit, held_hit, press, unpress;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (match[i]) hit_idx = IDX_W'(i);
  end

  assign hit      = lookup_en && (|match);
  assign held_hit = key_held[hit_idx];
  assign press    = hit && !is_brk && !held_hit;   // typematic makes fall out here
  assign unpress  = hit &&  is_brk &&  held_hit;

  // ---------------------------------------------------------------- repeat
  logic             rep_active, stop_rep, rep_tick;
  logic [IDX_W-1:0] rep_key;
  logic [15:0]      rep_cnt;

  assign stop_rep = self_test || (unpress && rep_key == hit_idx);
  // A press or stop on this edge pre-empts any pulse the old owner was due.
  assign rep_tick = rep_active && (rep_cnt == 16'd1) && !press && !stop_rep;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_active <= 1'b0;
      rep_key    <= '0;
      rep_cnt    <= '0;
    end else if (press) begin
      rep_active <= REPEAT_EN;
      rep_key    <= hit_idx;
      rep_cnt    <= REPEAT_DELAY;
    end else if (stop_rep) begin
      rep_active <= 1'b0;
    end else if (rep_active) begin
      rep_cnt <= (rep_cnt == 16'd1) ? REPEAT_PERIOD : rep_cnt - 16'd1;
    end
  end

  // ---------------------------------------------------------------- key slots
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic sel;
    assign sel = (hit_idx == IDX_W'(i));
    ps2_key_slot #(
      .CODE  (KEY_CODES[9*i +: 9]),
      .PULSE (PULSE_MASK[i])
    ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .code      (code),
      .match     (match[i]),
      .press     (press && sel),
      .unpress   (unpress && sel),
      .clear_all (self_test),
      .rep_tick  (rep_tick && (rep_key == IDX_W'(i))),
      .held      (key_held[i]),
      .key_out   (key_out[i])
    );
  end

  assign any_held = |key_held;

  // ---------------------------------------------------------------- event FIFO
  typedef struct packed {
    logic             make;
    logic [IDX_W-1:0] key;
  } event_t;

  event_t        mem [EVENT_DEPTH];
  event_t        ev_in, ev_head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_req, push, drop;

  assign ev_in    = '{make: press, key: hit_idx};
  assign full     = (count == (AW+1)'(EVENT_DEPTH));
  assign pop      = event_valid && event_ready;
  assign push_req = press || unpress;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ev_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  // Head fields are forced to 0 while empty so stale storage never shows.
  assign event_valid = (count != '0);
  assign ev_head     = mem[rd_ptr];
  assign event_make  = event_valid & ev_head.make;
  assign event_key   = event_valid ? ev_head.key : '0;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Self-checking bench for ps2_key_matrix: directed scenarios followed by a
// randomized byte stream, every cycle compared against a behavioural model
// that tracks prefixes as flags, keys as a bit table, events as a queue and
// auto-repeat as absolute pulse times.
module tb_ps2_key_matrix;
  localparam int             NK    = 10;
  localparam int             IW    = 4;
  localparam int             DEPTH = 4;
  localparam logic [NK-1:0]  PMASK = 10'h100;
  localparam int             RDLY  = 5;
  localparam int             RPER  = 3;
  localparam logic [8:0] CODES [NK] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h16B,
                                        9'h174, 9'h175, 9'h172, 9'h029, 9'h05A};

  logic          clock = 1'b0, reset = 1'b1;
  logic          byte_valid = 1'b0, event_ready = 1'b0, overflow_clear = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic [NK-1:0] key_held, key_out;
  logic          any_held, event_valid, event_make, overflow;
  logic [IW-1:0] event_key;

  ps2_key_matrix #(
    .NUM_KEYS(NK), .PULSE_MASK(PMASK), .REPEAT_DELAY(16'(RDLY)),
    .REPEAT_PERIOD(16'(RPER)), .EVENT_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_held(key_held), .key_out(key_out), .any_held(any_held),
    .event_valid(event_valid), .event_ready(event_ready), .event_make(event_make),
    .event_key(event_key), .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  // ---------------------------------------------------------------- model
  logic [NK-1:0] m_held, m_pulse;
  bit            m_ext, m_brk, m_ovf, rep_on;
  int            rep_key, next_rep, edge_n;
  logic [IW:0]   m_q[$];

  task automatic model_reset();
    m_held = '0; m_pulse = '0; m_ext = 0; m_brk = 0; m_ovf = 0;
    rep_on = 0; rep_key = 0; next_rep = 0; m_q.delete();
  endtask

  task automatic model_edge(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    int hit; bit pressed, have_ev, drop; logic [IW:0] ev;
    hit = -1; pressed = 0; have_ev = 0; drop = 0; ev = '0; m_pulse = '0;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (bv) begin
      if (b == 8'hE0) begin m_ext = 1; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFC)) begin
          m_held = '0; rep_on = 0;
        end else begin
          for (int i = NK - 1; i >= 0; i--) if (CODES[i] == {m_ext, b}) hit = i;
          if (hit >= 0) begin
            if (!m_brk && !m_held[hit]) begin
              m_held[hit] = 1; m_pulse[hit] = 1; pressed = 1;
              ev = {1'b1, IW'(hit)}; have_ev = 1;
              rep_on = 1; rep_key = hit; next_rep = edge_n + RDLY;
            end else if (m_brk && m_held[hit]) begin
              m_held[hit] = 0; ev = {1'b0, IW'(hit)}; have_ev = 1;
              if (hit == rep_key) rep_on = 0;
            end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
    if (!pressed && rep_on && edge_n == next_rep) begin
      m_pulse[rep_key] = 1; next_rep += RPER;
    end
    if (have_ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev); else drop = 1;
    end
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    edge_n++;
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NK-1:0] exp_out;
    exp_out = (PMASK & m_pulse) | (~PMASK & m_held);
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("key_out", 32'(key_out), 32'(exp_out));
    chk("any_held", 32'(any_held), 32'(|m_held));
    chk("event_valid", 32'(event_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("event_head", 32'({event_make, event_key}), 32'(m_q[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_held"}, 32'(key_held), 32'h0);
    chk({tag, "_out"}, 32'(key_out), 32'h0);
    chk({tag, "_any"}, 32'(any_held), 32'h0);
    chk({tag, "_valid"}, 32'(event_valid), 32'h0);
    chk({tag, "_head"}, 32'({event_make, event_key}), 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  // Entered and left on a negedge.
  task automatic step(input bit bv, input logic [7:0] b, input bit rdy, input bit clr);
    byte_valid = bv; byte_data = b; event_ready = rdy; overflow_clear = clr;
    @(posedge clock);
    model_edge(bv, b, rdy, clr);
    @(negedge clock);
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (event_valid) n++;
      step(0, 8'h00, 1, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, pcnt;
    model_reset(); edge_n = 0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    // Basic make/break on W (hold mode)
    send(8'h1D); idle(2); send(8'hF0); send(8'h1D);
    drain(n);
    chk("basic_events", n, 2);

    // Extended keys: E0 6B, bare 6B, E0 F0 6B
    send(8'hE0); send(8'h6B); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    drain(n);
    chk("ext_events", n, 2);

    // Pulse / repeat on Space with typematic repeats of the make code
    pcnt = 0;
    for (int c = 0; c < 30; c++) begin
      case (c)
        0, 3, 4: step(1, 8'h29, 0, 0);
        19:      step(1, 8'hF0, 0, 0);
        20:      step(1, 8'h29, 0, 0);
        default: step(0, 8'h00, 0, 0);
      endcase
      if (key_out[8]) pcnt++;
    end
    chk("repeat_pulses", pcnt, 6);
    drain(n);
    chk("repeat_events", n, 2);

    // Overflow: six distinct presses with no consumer
    do_reset();
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'h29); send(8'h5A);
    chk("ovf_set", 32'(overflow), 32'h1);
    step(0, 8'h00, 0, 1);
    chk("ovf_clear", 32'(overflow), 32'h0);
    send(8'hF0);
    step(1, 8'h1D, 1, 0);               // push and pop on a full FIFO
    chk("ovf_pushpop", 32'(overflow), 32'h0);
    drain(n);

    // Self-test byte clears held keys and silences the repeat
    do_reset();
    send(8'h1D); send(8'hE0); send(8'h75); send(8'h29);
    drain(n);
    send(8'hAA);
    pcnt = 0;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      if (key_out[8]) pcnt++;
    end
    chk("selftest_quiet", pcnt, 0);
    chk("selftest_events", 32'(event_valid), 32'h0);

    // Reset asserted between E0 and F0
    send(8'h1D); send(8'hE0); send(8'hF0);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    send(8'h1C);
    chk("post_reset_make", 32'(key_held[1]), 32'h1);
    drain(n);

    // Randomized byte stream
    for (int k = 0; k < 500; k++) begin
      int r; logic [7:0] b;
      r = $urandom_range(0, 15);
      if (r < NK)       b = CODES[r][7:0];
      else if (r == 10) b = 8'hE0;
      else if (r == 11) b = 8'hF0;
      else if (r == 12) b = 8'hAA;
      else if (r == 13) b = 8'hFC;
      else              b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_matrix.md
# ps2_key_matrix

Generalised PS/2 set-2 key tracker that replaces the fixed ten-key tracker. It consumes the byte stream from the PS/2 core driver (`received_data` / `received_data_en`). For a parameter-defined table of keys it produces:
- per-key held levels,
- per-key hold/pulse outputs with optional auto-repeat,
- a buffered make/break event stream with a valid/ready handshake.

It sits between the PS/2 controller and the game control FSM.

## Interface
Parameters:
- `NUM_KEYS`, 10: number of tracked keys, 1..32. `IDX_W` = max(1, clog2(NUM_KEYS)).
- `KEY_CODES`, 9*NUM_KEYS bits: key i occupies bits [9i+8:9i]. Bit 8 is the E0-extended flag; bits 7:0 are the scan code. The default places W, A, S, D, Left, Right, Up, Down, Space, Enter at indices 0..9, with codes 0x01D, 0x01C, 0x01B, 0x023, 0x16B, 0x174, 0x175, 0x172, 0x029, 0x05A.
- `PULSE_MASK`, NUM_KEYS bits, default 0: bit i=1 puts key i in pulse mode; bit i=0 puts it in hold mode.
- `REPEAT_DELAY`, 16 bits, default 0: cycles from the press pulse to the first repeat pulse. 0 disables auto-repeat.
- `REPEAT_PERIOD`, 16 bits, default 1: cycles between subsequent repeat pulses. Must be ≥1.
- `EVENT_DEPTH`, 4: event FIFO depth, a power of two ≥2.

Ports:
- `clock`  in  1: single clock. All logic is posedge.
- `reset`  in  1: asynchronous, active-high. It clears all state immediately.
- `byte_valid`  in  1: one-cycle strobe meaning a new keyboard byte is present.
- `byte_data`  in  8: the keyboard byte, valid while `byte_valid` is high.
- `key_held`  out  NUM_KEYS: level, high while the key is down.
- `key_out`  out  NUM_KEYS: `key_held` when the key's `PULSE_MASK` bit is 0, otherwise the press/repeat pulse.
- `any_held`  out  1: OR of `key_held`.
- `event_valid`  out  1: FIFO non-empty.
- `event_ready`  in  1: consumer accepts the head event when high together with `event_valid`.
- `event_make`  out  1: head event is a make (1) or a break (0).
- `event_key`  out  IDX_W: key index of the head event.
- `overflow`  out  1: sticky flag, set when an event is dropped.
- `overflow_clear`  in  1: clears `overflow`.

## Operation
- **Decoder FSM states:** IDLE, BRK, EXT, EXT_BRK. Transitions happen only on `byte_valid`.
- **Prefix bytes:**
  - 0xE0 → EXT, from any state.
  - 0xF0 → BRK from IDLE or BRK; → EXT_BRK from EXT or EXT_BRK.
- **Any other byte:**
  - Build `{ext, byte}` with ext=1 in EXT or EXT_BRK.
  - Look it up; the lowest matching index wins and no match is ignored.
  - Break = state is BRK or EXT_BRK.
  - Then return to IDLE.
- **Extended matching:** the extended flag must match exactly. An E0-prefixed 0x6B does not match code 0x06B.
- **Make of key i:**
  - Key not held: set held, emit a press pulse, push event {1,i}, and make i the repeat key.
  - Key already held (typematic): no effect.
- **Break of key i:**
  - Key held: clear held and push event {0,i}. If i is the repeat key, stop the repeat.
  - Key not held: no effect, no event.
- **Byte 0xAA or 0xFC received in IDLE (self-test / error):**
  - Clear all held bits and stop the repeat.
  - No events; the FIFO is untouched.
- **Auto-repeat** (REPEAT_DELAY≠0): one 16-bit counter serves the current repeat key only.
  - Counter loads REPEAT_DELAY on a press and decrements each cycle.
  - At 1 it emits a pulse on that key's pulse line and reloads REPEAT_PERIOD.
  - Repeat pulses push no events.
- **FIFO:**
  - Show-ahead; `event_*` show the head entry.
  - Pop when `event_valid && event_ready`.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped and `overflow` is set.
  - Set has priority over `overflow_clear` in the same cycle.
- **Reset values:** all outputs 0, FSM in IDLE, FIFO empty, repeat inactive.

## Timing
- `byte_valid` at edge t → `key_held` and FSM state update at t+1.
- The press pulse is high for exactly the one cycle following t+1, i.e. visible during cycle t+1.
- Event pushed at t+1. With the FIFO previously empty, `event_valid` is high from t+1.
- Repeat pulses fall at cycles t+1+REPEAT_DELAY, then every REPEAT_PERIOD after that, while the key stays held.
- A break at edge u clears held at u+1. No repeat pulse occurs at or after u+1.
- A new press of a different key moves repeat ownership at its press cycle. The old key gets no further pulses and stays held.
- Reset asserted mid-sequence (e.g. after E0 F0): state is IDLE on deassertion; the next byte is decoded as a fresh code.
- Throughput: one byte per cycle is sustained. At most one push per cycle.

## Test plan
- **Basic make/break:** bytes 1D, then F0 1D → `key_held[0]` high for the interval between the bytes. `key_out[0]` follows it (hold mode). Events {1,0} then {0,0} appear; `event_valid` is high from the cycle after the first byte.
- **Extended keys:** E0 6B, then 6B, then E0 F0 6B →
  - after the first E0 6B: `key_held[4]` is 1;
  - bare 6B matches nothing and changes nothing;
  - after E0 F0 6B: `key_held[4]` is 0;
  - exactly two events: {1,4}, {0,4}.
- **Pulse/repeat:** PULSE_MASK=1<<8, REPEAT_DELAY=5, REPEAT_PERIOD=3. Send 29 at cycle 0, then 29 29 (typematic), and F0 29 at cycle 20 → `key_out[8]` pulses at cycles 1, 6, 9, 12, 15, 18, then stops. Typematic bytes add no pulses or events.
- **Overflow:** EVENT_DEPTH=4, `event_ready`=0, six distinct presses → four events retained in order, `overflow`=1. `overflow_clear` → 0. With the FIFO full, a push and pop in the same cycle → no overflow.
- **Self-test and reset:** hold W and Up, then send AA → both held bits 0, no events, repeat silent. Assert `reset` between E0 and F0 → all outputs 0 at once; a following 1C sets `key_held[1]`.
